// File: rtl/oam_dma_master_pkg.sv
// +----------------------------------------------------------------------------+
// | DmaPkg                                                                     |
// | Shared state encoding and bus constants for the sprite DMA initiator.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package DmaPkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        GET   = 3'd3,
        PUT   = 3'd4
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam int          DMA_XFER_LEN  = 256;

endpackage

`default_nettype wire

// File: rtl/oam_dma_master_cpu_cycle_parity.sv
// +----------------------------------------------------------------------------+
// | cpu_cycle_parity                                                           |
// | Get/put phase of the CPU: toggles on every CPU cycle strobe.               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_cycle_parity (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_ce,
    output logic parity
);

    logic parity_d;
    logic parity_q;

    always_comb begin
        parity_d = cpu_ce ? ~parity_q : parity_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;

endmodule

`default_nettype wire

// File: rtl/oam_dma_master.sv
// +----------------------------------------------------------------------------+
// | oam_dma_master                                                             |
// | Halts the CPU and copies one 256-byte page to the PPU OAM data port.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module oam_dma_master
    import DmaPkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DmaPkg::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = DmaPkg::OAM_DATA_ADDR,
    parameter int          XFER_LEN      = DMA_XFER_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce,
    input  logic        cpu_cs,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        dma_active,
    output logic        cpu_halt,
    output logic        bus_cs,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        dma_done
);

    localparam int            CW   = $clog2(XFER_LEN);
    localparam logic [CW-1:0] LAST = CW'(XFER_LEN - 1);

    dma_state_t    state_d, state_q;
    logic [7:0]    page_d, page_q;
    logic [CW-1:0] count_d, count_q;
    logic [7:0]    data_d, data_q;
    logic          active_d, active_q;
    logic          halt_d, halt_q;
    logic          cs_d, cs_q;
    logic          rd_d, rd_q;
    logic          wr_d, wr_q;
    logic [15:0]   addr_d, addr_q;
    logic [7:0]    dout_d, dout_q;
    logic          done_d, done_q;
    logic          parity;

    cpu_cycle_parity u_parity (
        .clk    (clk),
        .rst_n  (rst_n),
        .cpu_ce (cpu_ce),
        .parity (parity)
    );

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        count_d = count_q;
        data_d  = data_q;
        done_d  = 1'b0;

        if (cpu_ce) begin
            case (state_q)
                IDLE: begin
                    if (!cpu_cs && cpu_wr && cpu_addr == DMA_REG_ADDR) begin
                        page_d  = cpu_dout;
                        state_d = HALT;
                    end
                end
                // Parity has toggled once since the trigger, so a clear bit
                // here means the trigger landed on an odd cycle.
                HALT:  state_d = parity ? GET : ALIGN;
                ALIGN: state_d = GET;
                GET: begin
                    data_d  = bus_din;
                    state_d = PUT;
                end
                PUT: begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GET;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Bus outputs are registered from the next state so they line up with it.
        active_d = (state_d != IDLE);
        halt_d   = (state_d != IDLE);
        cs_d     = 1'b1;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = 16'h0000;
        dout_d   = 8'h00;
        case (state_d)
            GET: begin
                cs_d   = 1'b0;
                rd_d   = 1'b1;
                addr_d = {page_d, 8'(count_d)};
            end
            PUT: begin
                cs_d   = 1'b0;
                wr_d   = 1'b1;
                addr_d = OAM_DATA_ADDR;
                dout_d = data_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            count_q  <= '0;
            data_q   <= 8'h00;
            active_q <= 1'b0;
            halt_q   <= 1'b0;
            cs_q     <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 16'h0000;
            dout_q   <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            count_q  <= count_d;
            data_q   <= data_d;
            active_q <= active_d;
            halt_q   <= halt_d;
            cs_q     <= cs_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    assign dma_active = active_q;
    assign cpu_halt   = halt_q;
    assign bus_cs     = cs_q;
    assign bus_rd     = rd_q;
    assign bus_wr     = wr_q;
    assign bus_addr   = addr_q;
    assign bus_dout   = dout_q;
    assign dma_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_master.sv
// +----------------------------------------------------------------------------+
// | tb_oam_dma_master                                                          |
// | Scoreboard bench: directed triggers queue expected bus beats and done.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_oam_dma_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_ce = 1'b0;
    logic        cpu_cs = 1'b1;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        dma_active, cpu_halt, bus_cs, bus_rd, bus_wr, dma_done;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din = 8'h00;

    oam_dma_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_ce     (cpu_ce),
        .cpu_cs     (cpu_cs),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .dma_active (dma_active),
        .cpu_halt   (cpu_halt),
        .bus_cs     (bus_cs),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_din    (bus_din),
        .dma_done   (dma_done)
    );

    always #5 clk = ~clk;

    // CPU cycle strobe: high for one clk out of every two
    initial begin
        forever begin
            @(posedge clk);
            #1 cpu_ce = ~cpu_ce;
        end
    end

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (!bus_cs && bus_rd) bus_din <= mem[bus_addr];
    end

    int ce_n;
    always @(posedge clk) begin
        if (!rst_n)      ce_n <= 0;
        else if (cpu_ce) ce_n <= ce_n + 1;
    end

    typedef struct {
        bit          is_done;
        bit          rd;
        logic [15:0] addr;
        logic [7:0]  data;
        int          halts;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   halt_cnt = 0;
    int   get_beats = 0;

    // Monitor: samples mid-cycle, just before the clk edge that consumes cpu_ce.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            halt_cnt = 0;
            q.delete();
        end else begin
            if (cpu_ce && cpu_halt) halt_cnt++;
            if (cpu_ce && !bus_cs) begin
                n_cmp++;
                if (q.size() == 0 || q[0].is_done) begin
                    n_bad++;
                    $display("FAIL beat: unexpected bus cycle rd=%b wr=%b addr=%h dout=%h, none required",
                             bus_rd, bus_wr, bus_addr, bus_dout);
                end else begin
                    e = q.pop_front();
                    if (e.rd) get_beats++;
                    if (bus_rd !== e.rd || bus_wr !== !e.rd || bus_addr !== e.addr ||
                        (!e.rd && bus_dout !== e.data) || dma_active !== 1'b1) begin
                        n_bad++;
                        $display("FAIL beat: got rd=%b wr=%b addr=%h dout=%h act=%b, required rd=%b wr=%b addr=%h dout=%h act=1",
                                 bus_rd, bus_wr, bus_addr, bus_dout, dma_active,
                                 e.rd, !e.rd, e.addr, e.data);
                    end
                end
            end
            if (dma_done) begin
                n_cmp++;
                if (q.size() == 0 || !q[0].is_done) begin
                    n_bad++;
                    $display("FAIL done: unexpected dma_done pulse (queue depth %0d), none required", q.size());
                end else begin
                    e = q.pop_front();
                    if (halt_cnt != e.halts || cpu_halt !== 1'b0 || dma_active !== 1'b0) begin
                        n_bad++;
                        $display("FAIL done: halted cycles=%0d halt=%b act=%b, required %0d halt=0 act=0",
                                 halt_cnt, cpu_halt, dma_active, e.halts);
                    end
                end
                halt_cnt = 0;
            end
        end
    end

    task automatic wait_ce_neg();
        @(negedge clk);
        while (!cpu_ce) @(negedge clk);
    endtask

    task automatic drive_bus(input logic [15:0] a, input logic [7:0] d,
                             input logic cs, input logic wr);
        cpu_cs   = cs;
        cpu_wr   = wr;
        cpu_addr = a;
        cpu_dout = d;
        @(posedge clk);
        #1;
        cpu_cs   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
    endtask

    task automatic push_xfer(input logic [7:0] pg, input bit odd);
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            e.is_done = 1'b0;
            e.rd      = 1'b1;
            e.addr    = {pg, 8'(i)};
            e.data    = 8'h00;
            e.halts   = 0;
            q.push_back(e);
            e.rd      = 1'b0;
            e.addr    = 16'h2004;
            e.data    = mem[{pg, 8'(i)}];
            q.push_back(e);
        end
        e.is_done = 1'b1;
        e.rd      = 1'b0;
        e.addr    = 16'h0000;
        e.data    = 8'h00;
        e.halts   = odd ? 514 : 513;
        q.push_back(e);
    endtask

    // par: 0 = even start, 1 = odd start, -1 = whichever CPU cycle comes first
    task automatic start_dma(input logic [7:0] pg, input int par);
        wait_ce_neg();
        if (par >= 0 && ce_n[0] != par[0]) wait_ce_neg();
        push_xfer(pg, ce_n[0]);
        drive_bus(16'h4014, pg, 1'b0, 1'b1);
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!dma_done && t < 3000);
        if (!dma_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: dma_done=0 after %0d clks, required a pulse", t);
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if ({dma_active, cpu_halt, bus_cs, bus_rd, bus_wr, dma_done} !== 6'b001000 ||
            bus_addr !== 16'h0000 || bus_dout !== 8'h00) begin
            n_bad++;
            $display("FAIL %s: act=%b halt=%b cs=%b rd=%b wr=%b done=%b addr=%h dout=%h, required 0 0 1 0 0 0 0000 00",
                     name, dma_active, cpu_halt, bus_cs, bus_rd, bus_wr, dma_done, bus_addr, bus_dout);
        end
    endtask

    initial begin
        int base;
        int t;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = (i[15:8] == 8'h03) ? (i[7:0] ^ 8'hA5) : 8'(i * 7 + (i >> 8));
        end

        repeat (4) @(posedge clk);
        #1 check_idle("reset");
        rst_n = 1'b1;

        start_dma(8'h02, 0);
        wait_done();
        start_dma(8'h02, 1);
        wait_done();
        start_dma(8'h03, -1);
        wait_done();

        // Near-miss accesses must leave the block idle
        wait_ce_neg(); drive_bus(16'h4015, 8'h02, 1'b0, 1'b1);
        repeat (4) @(negedge clk); check_idle("filter_4015");
        wait_ce_neg(); drive_bus(16'h4013, 8'h02, 1'b0, 1'b1);
        repeat (4) @(negedge clk); check_idle("filter_4013");
        wait_ce_neg(); drive_bus(16'h4014, 8'h02, 1'b1, 1'b1);
        repeat (4) @(negedge clk); check_idle("filter_cs_high");
        wait_ce_neg(); drive_bus(16'h4014, 8'h02, 1'b0, 1'b0);
        repeat (4) @(negedge clk); check_idle("filter_read");

        start_dma(8'h05, -1);
        wait_done();
        start_dma(8'h06, -1);
        repeat (40) @(negedge clk);
        wait_ce_neg();
        drive_bus(16'h4014, 8'h07, 1'b0, 1'b1);
        wait_done();

        start_dma(8'h04, -1);
        base = get_beats;
        t = 0;
        while (get_beats < base + 100 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (get_beats < base + 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d reads before reset point, required 100", get_beats - base);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 check_idle("mid_reset");
        repeat (6) @(posedge clk);
        #1 check_idle("reset_hold");
        rst_n = 1'b1;
        start_dma(8'h04, -1);
        wait_done();

        repeat (6) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected events outstanding, required 0", q.size());
        end
        check_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
